// File: rtl/rx_multi_sampler_if.sv
// Bus between a serial receiver front end and its oversampling bit sampler.
// The receiver controller drives the master side; the sampler is the slave.
interface rx_multi_sampler_if #(
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  samp_en;
  logic                  bit_restart;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic                  bit_tick;
  logic                  sampled_bit;
  logic                  bit_valid;
  logic                  noise_flag;
  logic                  cfg_err;

  modport master (
    output RX_IN, Prescale, samp_en, bit_restart,
    input  edge_cnt, bit_tick, sampled_bit, bit_valid, noise_flag, cfg_err
  );

  modport slave (
    input  RX_IN, Prescale, samp_en, bit_restart,
    output edge_cnt, bit_tick, sampled_bit, bit_valid, noise_flag, cfg_err
  );
endinterface

// File: rtl/rx_multi_sampler.sv
// Oversampling serial bit sampler: synchronises RX_IN, tracks position within the
// bit period and majority-votes NUM_SAMPLES samples centred on the bit middle.
module rx_multi_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3,
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RST,
  rx_multi_sampler_if.slave bus
);

  localparam int CNT_W = 3;
  localparam int M     = (NUM_SAMPLES - 1) / 2;

  typedef logic [PRESCALE_W-1:0] pre_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  localparam pre_t ONE       = pre_t'(1);
  localparam pre_t TWO       = pre_t'(2);
  localparam pre_t MIN_PRE   = pre_t'(NUM_SAMPLES + 1);
  localparam pre_t HALF_SPAN = pre_t'(M);
  localparam cnt_t MAJ       = cnt_t'(NUM_SAMPLES / 2);
  localparam cnt_t ALL_ONES  = cnt_t'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_DEGRADED,
    MODE_NORMAL
  } mode_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  pre_t                   pre_q;
  pre_t                   edge_q;
  pre_t                   half;
  pre_t                   samp_lo;
  pre_t                   samp_hi;
  mode_e                  mode;
  logic                   run;
  logic                   wrap;
  logic                   in_window;
  logic                   last_sample;
  cnt_t                   ones_q;
  cnt_t                   ones_nxt;
  logic                   valid_q;
  logic                   sampled_q;
  logic                   noise_q;
  logic                   cfg_err_q;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // pre_q is the bit-period length of the window in progress; it only follows
  // Prescale at a wrap or restart so a mid-bit change cannot stretch this bit.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    half    = pre_q >> 1;
    mode    = MODE_OFF;
    samp_lo = '0;
    samp_hi = '0;
    if (pre_q >= MIN_PRE) begin
      mode    = MODE_NORMAL;
      samp_lo = half - HALF_SPAN;
      samp_hi = half + HALF_SPAN;
    end else if (pre_q >= TWO) begin
      mode    = MODE_DEGRADED;
      samp_lo = half;
      samp_hi = half;
    end
    run         = bus.samp_en & ~bus.bit_restart;
    wrap        = (mode == MODE_OFF) | (edge_q == pre_q - ONE);
    in_window   = run & (mode != MODE_OFF) & (edge_q >= samp_lo) & (edge_q <= samp_hi);
    last_sample = in_window & (edge_q == samp_hi);
    ones_nxt    = ones_q + {{(CNT_W-1){1'b0}}, rx_s};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '1;
      pre_q     <= bus.Prescale;
      edge_q    <= '0;
      ones_q    <= '0;
      valid_q   <= 1'b0;
      sampled_q <= 1'b1;
      noise_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.RX_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      cfg_err_q <= (bus.Prescale < MIN_PRE);
      valid_q   <= last_sample;
      if (!run) begin
        edge_q <= '0;
        ones_q <= '0;
        pre_q  <= bus.Prescale;
      end else begin
        if (wrap) begin
          edge_q <= '0;
          pre_q  <= bus.Prescale;
        end else begin
          edge_q <= edge_q + ONE;
        end
        if (last_sample) begin
          ones_q    <= '0;
          sampled_q <= (ones_nxt > MAJ);
          noise_q   <= (mode == MODE_NORMAL) & (ones_nxt != '0) & (ones_nxt != ALL_ONES);
        end else if (in_window) begin
          ones_q <= ones_nxt;
        end
      end
    end
  end

  assign bus.edge_cnt    = edge_q;
  assign bus.bit_tick    = run & (edge_q == pre_q - ONE);
  assign bus.bit_valid   = valid_q & bus.samp_en;
  assign bus.sampled_bit = sampled_q;
  assign bus.noise_flag  = noise_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_rx_multi_sampler.sv
// Bench for rx_multi_sampler: a 3-sample and a 5-sample instance run against a
// sample-list reference model plus directed scenarios with literal expectations.
module tb_rx_multi_sampler;

  localparam int PW = 6;
  localparam int N3 = 3;
  localparam int S3 = 2;
  localparam int N5 = 5;
  localparam int S5 = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          en = 1'b0;
  logic          restart = 1'b0;
  logic          rx3 = 1'b1;
  logic          rx5 = 1'b1;
  logic [PW-1:0] p3 = PW'(8);
  logic [PW-1:0] p5 = PW'(16);
  bit            cmp_on = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  always #5 CLK = ~CLK;

  rx_multi_sampler_if #(.PRESCALE_W(PW)) bus3 ();
  rx_multi_sampler_if #(.PRESCALE_W(PW)) bus5 ();

  assign bus3.RX_IN       = rx3;
  assign bus3.Prescale    = p3;
  assign bus3.samp_en     = en;
  assign bus3.bit_restart = restart;
  assign bus5.RX_IN       = rx5;
  assign bus5.Prescale    = p5;
  assign bus5.samp_en     = en;
  assign bus5.bit_restart = restart;

  rx_multi_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(N3), .SYNC_STAGES(S3)) dut3 (
    .CLK(CLK), .RST(RST), .bus(bus3)
  );
  rx_multi_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(N5), .SYNC_STAGES(S5)) dut5 (
    .CLK(CLK), .RST(RST), .bus(bus5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: a delay line for the synchroniser, a position counter and
  // the list of sample positions for the current window length.
  int m_cnt[2];
  int m_pre[2];
  int m_nsmp[2];
  bit m_smp[2][8];
  bit m_hist[2][4];
  bit m_vq[2];
  bit m_sb[2];
  bit m_nf[2];
  bit m_cfg[2];

  task automatic model_step(input int d, input int n, input int sync, input bit rx,
                            input int p, input bit en_i, input bit rs_i, input bit rst_i);
    int h, lo, hi, ones;
    bit rxs;
    if (rst_i) begin
      m_cnt[d] = 0; m_pre[d] = p; m_nsmp[d] = 0;
      m_vq[d] = 0; m_sb[d] = 1; m_nf[d] = 0; m_cfg[d] = 0;
      for (int i = 0; i < 4; i++) m_hist[d][i] = 1'b1;
      return;
    end
    rxs      = m_hist[d][sync-1];
    m_cfg[d] = (p < n + 1);
    m_vq[d]  = 0;
    if (en_i && !rs_i) begin
      h = m_pre[d] / 2;
      if (m_pre[d] >= n + 1) begin lo = h - (n - 1) / 2; hi = h + (n - 1) / 2; end
      else if (m_pre[d] >= 2) begin lo = h; hi = h; end
      else begin lo = 1; hi = 0; end
      if (m_cnt[d] >= lo && m_cnt[d] <= hi) begin
        m_smp[d][m_nsmp[d]] = rxs;
        m_nsmp[d]++;
        if (m_nsmp[d] == hi - lo + 1) begin
          ones = 0;
          for (int i = 0; i < m_nsmp[d]; i++) ones += int'(m_smp[d][i]);
          m_vq[d]  = 1;
          m_sb[d]  = (ones > n / 2);
          m_nf[d]  = (hi > lo) && (ones != 0) && (ones != m_nsmp[d]);
          m_nsmp[d] = 0;
        end
      end
      if (m_pre[d] < 2 || m_cnt[d] == m_pre[d] - 1) begin m_cnt[d] = 0; m_pre[d] = p; end
      else m_cnt[d]++;
    end else begin
      m_cnt[d] = 0; m_nsmp[d] = 0; m_pre[d] = p;
    end
    for (int i = sync - 1; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
    m_hist[d][0] = rx;
  endtask

  always @(posedge CLK) begin
    model_step(0, N3, S3, rx3, int'(p3), en, restart, RST);
    model_step(1, N5, S5, rx5, int'(p5), en, restart, RST);
  end

  task automatic cmp(input int d, input string tag, input logic [PW-1:0] ec, input logic tk,
                     input logic bv, input logic sb, input logic nf, input logic ce);
    bit exp_tk;
    exp_tk = en && !restart && (m_cnt[d] == m_pre[d] - 1);
    check({tag, ".edge_cnt"}, 32'(ec), m_cnt[d]);
    check({tag, ".bit_tick"}, 32'(tk), 32'(exp_tk));
    check({tag, ".bit_valid"}, 32'(bv), 32'(m_vq[d] & en));
    check({tag, ".sampled_bit"}, 32'(sb), 32'(m_sb[d]));
    check({tag, ".noise_flag"}, 32'(nf), 32'(m_nf[d]));
    check({tag, ".cfg_err"}, 32'(ce), 32'(m_cfg[d]));
  endtask

  always @(negedge CLK) begin
    #2;
    if (cmp_on) begin
      cmp(0, "d3", bus3.edge_cnt, bus3.bit_tick, bus3.bit_valid, bus3.sampled_bit,
          bus3.noise_flag, bus3.cfg_err);
      cmp(1, "d5", bus5.edge_cnt, bus5.bit_tick, bus5.bit_valid, bus5.sampled_bit,
          bus5.noise_flag, bus5.cfg_err);
    end
  end

  // Called at a negedge; returns at the negedge where edge_cnt has just been zeroed.
  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
  endtask

  bit exp_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int g_base[4]   = '{0, 0, 1, 1};
  int g_first[4]  = '{8, 7, 6, 0};
  int g_len[4]    = '{1, 3, 1, 0};
  int g_bit[4]    = '{0, 1, 1, 1};
  int g_noise[4]  = '{1, 1, 1, 0};

  initial begin
    int ticks, valids, nv, vb, vn, vedge;
    bit seen, base;
    int tick_at[$];
    int valid_at[$];

    repeat (2) @(negedge CLK);
    cmp_on = 1'b1;
    check("reset edge_cnt", 32'(bus3.edge_cnt), 0);
    check("reset sampled_bit", 32'(bus3.sampled_bit), 1);
    check("reset noise_flag", 32'(bus5.noise_flag), 0);
    check("reset cfg_err", 32'(bus3.cfg_err), 0);
    check("reset bit_valid", 32'(bus5.bit_valid), 0);

    // RX held low, Prescale 8: samples at 3,4,5, bit_valid seen at edge_cnt 6
    rx3 = 1'b0; rx5 = 1'b0; RST = 1'b0;
    repeat (3) @(negedge CLK);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (bus3.bit_valid) begin
        seen = 1'b1;
        check("p8 valid edge_cnt", 32'(bus3.edge_cnt), 6);
        check("p8 sampled_bit", 32'(bus3.sampled_bit), 0);
        check("p8 noise_flag", 32'(bus3.noise_flag), 0);
      end
    end
    check("p8 valid within bound", 32'(seen), 1);

    // Four back-to-back bits with Prescale 8
    pulse_restart();
    check("restart edge_cnt", 32'(bus3.edge_cnt), 0);
    ticks = 0; valids = 0;
    for (int c = 0; c < 32; c++) begin
      if (c % 8 == 0) rx3 = exp_bits[c / 8];
      @(negedge CLK);
      if (bus3.bit_tick) begin
        ticks++;
        check("tick edge_cnt", 32'(bus3.edge_cnt), 7);
      end
      if (bus3.bit_valid) begin
        if (valids < 4) check("stream sampled_bit", 32'(bus3.sampled_bit), 32'(exp_bits[valids]));
        valids++;
      end
    end
    check("stream tick count", ticks, 4);
    check("stream valid count", valids, 4);

    // Five-sample majority vote with glitches, Prescale 16 (samples at 6..10)
    for (int r = 0; r < 4; r++) begin
      base = g_base[r][0];
      rx5 = base;
      pulse_restart();
      nv = 0; vb = -1; vn = -1;
      for (int e = 0; e < 16; e++) begin
        rx5 = (e >= g_first[r] - S5 && e < g_first[r] - S5 + g_len[r]) ? ~base : base;
        @(negedge CLK);
        if (bus5.bit_valid) begin
          nv++;
          vb = int'(bus5.sampled_bit);
          vn = int'(bus5.noise_flag);
          check("n5 valid edge_cnt", 32'(bus5.edge_cnt), 11);
        end
      end
      check("n5 valid count", nv, 1);
      check("n5 sampled_bit", vb, g_bit[r]);
      check("n5 noise_flag", vn, g_noise[r]);
    end

    // Degraded mode: Prescale 3 uses one sample at edge_cnt 1
    p3 = PW'(3); rx3 = 1'b0;
    @(negedge CLK);
    pulse_restart();
    check("p3 cfg_err", 32'(bus3.cfg_err), 1);
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus3.bit_valid) begin
        nv++;
        check("p3 valid edge_cnt", 32'(bus3.edge_cnt), 2);
        check("p3 sampled_bit", 32'(bus3.sampled_bit), 0);
        check("p3 noise_flag", 32'(bus3.noise_flag), 0);
      end
    end
    check("p3 valid count", nv, 2);

    // Prescale 1: counter parked at 0, never a bit_valid
    p3 = PW'(1);
    pulse_restart();
    check("p1 cfg_err", 32'(bus3.cfg_err), 1);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("p1 edge_cnt", 32'(bus3.edge_cnt), 0);
      if (bus3.bit_valid) nv++;
    end
    check("p1 valid count", nv, 0);

    // Restart on the last sample aborts the bit; the next bit samples normally
    p3 = PW'(8); rx3 = 1'b0;
    @(negedge CLK);
    pulse_restart();
    repeat (5) @(negedge CLK);
    check("abort at last sample edge_cnt", 32'(bus3.edge_cnt), 5);
    restart = 1'b1; rx3 = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    check("abort edge_cnt", 32'(bus3.edge_cnt), 0);
    check("abort bit_valid", 32'(bus3.bit_valid), 0);
    nv = 0; vedge = -1; vb = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus3.bit_valid) begin
        nv++; vedge = int'(bus3.edge_cnt); vb = int'(bus3.sampled_bit);
      end
    end
    check("after abort valid count", nv, 1);
    check("after abort valid edge_cnt", vedge, 6);
    check("after abort sampled_bit", vb, 1);

    // Reset mid-bit with samp_en high
    rx3 = 1'b0;
    pulse_restart();
    repeat (12) @(negedge CLK);
    check("pre-reset edge_cnt", 32'(bus3.edge_cnt), 4);
    check("pre-reset sampled_bit", 32'(bus3.sampled_bit), 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mid reset edge_cnt", 32'(bus3.edge_cnt), 0);
    check("mid reset bit_tick", 32'(bus3.bit_tick), 0);
    check("mid reset bit_valid", 32'(bus3.bit_valid), 0);
    check("mid reset sampled_bit", 32'(bus3.sampled_bit), 1);
    check("mid reset noise_flag", 32'(bus5.noise_flag), 0);
    check("mid reset cfg_err", 32'(bus3.cfg_err), 0);
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus3.bit_valid) nv++;
    end
    check("no valid after reset abort", nv, 0);

    // Prescale change mid-bit takes effect only from the next bit
    pulse_restart();
    repeat (2) @(negedge CLK);
    p3 = PW'(16);
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      if (bus3.bit_tick) tick_at.push_back(c);
      if (bus3.bit_valid) valid_at.push_back(c);
    end
    check("retune tick count", tick_at.size(), 2);
    check("retune valid count", valid_at.size(), 2);
    if (tick_at.size() == 2) begin
      check("retune old tick", tick_at[0], 4);
      check("retune new tick", tick_at[1], 20);
    end
    if (valid_at.size() == 2) begin
      check("retune old valid", valid_at[0], 3);
      check("retune new valid", valid_at[1], 15);
    end

    // samp_en low forces the counter to 0 and suppresses strobes
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("disabled edge_cnt", 32'(bus3.edge_cnt), 0);
      check("disabled bit_valid", 32'(bus3.bit_valid), 0);
    end

    repeat (2) @(negedge CLK);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_multi_sampler.md
RX_MULTI_SAMPLER -- requirements
Module: rx_multi_sampler

Interface
REQ-001 SHALL provide parameter PRESCALE_W, default 6, width of Prescale and edge_cnt.
REQ-002 SHALL provide parameter NUM_SAMPLES, default 3, samples per bit; legal values are odd, 1..7.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2, RX_IN synchroniser depth; legal values are 1..4.
REQ-004 SHALL provide port CLK, input, 1, oversampling clock; the single clock, all logic on its rising edge.
REQ-005 SHALL provide port RST, input, 1, reset; synchronous and active-high.
REQ-006 SHALL provide port RX_IN, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL provide port Prescale, input, PRESCALE_W, oversampling ratio (clocks per bit).
REQ-008 SHALL provide port samp_en, input, 1, enables counting and sampling.
REQ-009 SHALL provide port bit_restart, input, 1, realigns the bit window (e.g. on detected start edge).
REQ-010 SHALL provide port edge_cnt, output, PRESCALE_W, current position within bit period.
REQ-011 SHALL provide port bit_tick, output, 1, one-cycle pulse on last clock of each bit period.
REQ-012 SHALL provide port sampled_bit, output, 1, registered majority-vote result.
REQ-013 SHALL provide port bit_valid, output, 1, one-cycle pulse qualifying sampled_bit/noise_flag.
REQ-014 SHALL provide port noise_flag, output, 1, samples of the last bit not unanimous.
REQ-015 SHALL provide port cfg_err, output, 1, Prescale illegal for NUM_SAMPLES.

Function
REQ-016 RX_IN SHALL pass through SYNC_STAGES flops (reset value 1); all sampling SHALL use the last stage (rx_s).
REQ-017 When samp_en=1 and bit_restart=0, edge_cnt SHALL increment each clock, wrapping from Prescale-1 to 0.
REQ-018 When samp_en=0, edge_cnt SHALL be forced to 0, the sample accumulator cleared, and bit_tick/bit_valid held 0.
REQ-019 bit_restart=1 SHALL load edge_cnt=0 and clear the accumulator next cycle, overriding samp_en and any same-cycle sample capture or bit_valid generation for the aborted bit.
REQ-020 bit_tick SHALL be combinational: samp_en & ~bit_restart & (edge_cnt==Prescale-1).
REQ-021 With H=Prescale>>1 and M=(NUM_SAMPLES-1)/2, sample k (k=0..NUM_SAMPLES-1) SHALL capture rx_s when edge_cnt==H-M+k.
REQ-022 Prescale SHALL be legal iff Prescale >= NUM_SAMPLES+1; odd Prescale values are legal.
REQ-023 If 2 <= Prescale < NUM_SAMPLES+1, cfg_err SHALL be 1 and a single sample at edge_cnt==H SHALL be used (degraded mode).
REQ-024 If Prescale < 2, cfg_err SHALL be 1, edge_cnt SHALL stay 0 and bit_valid SHALL never assert.
REQ-025 cfg_err SHALL be a registered function of Prescale, updated every clock independent of samp_en.
REQ-026 The cycle after the last sample of a bit is captured, bit_valid SHALL pulse for exactly one clock.
REQ-027 In that same cycle sampled_bit SHALL equal 1 iff the count of ones among the samples > NUM_SAMPLES/2 (integer division).
REQ-028 In that same cycle noise_flag SHALL be 1 iff the samples are not all equal; in degraded mode noise_flag SHALL be 0.
REQ-029 sampled_bit and noise_flag SHALL hold their values until the next bit_valid.
REQ-030 Prescale changes SHALL be honoured only at edge_cnt wrap or bit_restart; mid-bit changes SHALL NOT corrupt the current window.
REQ-031 Latency from RX_IN change to its visibility at rx_s SHALL be exactly SYNC_STAGES clocks.

Reset
REQ-032 On RST=1 at a clock edge: edge_cnt=0, bit_tick=0, bit_valid=0, sampled_bit=1, noise_flag=0, cfg_err=0, synchroniser=all 1, accumulator cleared.
REQ-033 RST SHALL override samp_en, bit_restart and an in-progress bit; no bit_valid SHALL follow a reset-aborted bit.

Verification
REQ-034 Prescale=8, NUM_SAMPLES=3, RX_IN held 0 -> samples at edge_cnt 3,4,5; bit_valid at edge_cnt 6; sampled_bit=0, noise_flag=0.
REQ-035 Prescale=16, NUM_SAMPLES=5, one-clock high glitch at the middle sample only -> sampled_bit=0, noise_flag=1.
REQ-036 Prescale=3, NUM_SAMPLES=3 -> cfg_err=1, single sample at edge_cnt 1, noise_flag=0; Prescale=1 -> no bit_valid.
REQ-037 bit_restart asserted same cycle as last sample -> no bit_valid, edge_cnt=0 next cycle, the following bit is sampled normally.
REQ-038 RST asserted mid-bit with samp_en=1 -> all outputs at reset values next cycle; no bit_valid for the aborted bit.
REQ-039 Continuous samp_en, Prescale=8, 4 bits -> bit_tick every 8 clocks at edge_cnt 7; bit_valid once per bit.
